apb_rtc_multi_alarm: RTL and testbench
======================================

Name: apb_rtc_multi_alarm

Overview:
- APB3 slave real-time counter: binary seconds counter driven by a programmable prescaler, plus NUM_ALARMS independent compare channels.
- Each channel runs one-shot or periodic and has sticky status and an interrupt enable.
- One combined level interrupt goes to the event unit.
- Single clock domain (pclk); the 1 Hz tick is derived internally. This block is the successor to the BCD calendar RTC.

Parameters:
- CNT_W, 32, seconds counter width; also the width of compare and period registers (8..32).
- DIV_W, 16, prescaler width (4..24).
- NUM_ALARMS, 4, number of compare channels (1..8).
- PRESC_RST, 32767, reset value of the PRESC register.

Ports:
- pclk  input  1  APB and core clock.
- prst_n  input  1  Reset. Asynchronous, active-low; clock pclk.
- psel  input  1  APB select.
- penable  input  1  APB access phase.
- pwrite  input  1  1 = write.
- paddr  input  12  Byte address; only [7:2] decoded.
- pwdata  input  32  Write data.
- prdata  output  32  Read data.
- pready  output  1  Tied to 1.
- pslverr  output  1  Error response.
- tick_o  output  1  One-cycle pulse on every seconds increment.
- irq_o  output  1  Level interrupt.

Behaviour:
- Access qualifiers:
  - wr = psel & penable & pwrite; rd = psel & penable & ~pwrite.
  - prdata is combinational when rd is high, otherwise 0.
  - Unused register bits read 0.
  - pslverr = psel & penable & unmapped address. Writes to unmapped addresses are ignored.
- Register map (byte offsets):
  - 0x00 CTRL: [0] EN, [1] GIE. Reset 0.
  - 0x04 PRESC: [DIV_W-1:0]. Reset PRESC_RST.
  - 0x08 COUNT: [CNT_W-1:0]. Reset 0.
  - 0x0C STATUS: [NUM_ALARMS-1:0] alarm pending, [31] overflow. Write-1-to-clear. Reset 0.
  - 0x10 CHEN: per-channel armed bits. Reset 0.
  - 0x14 IRQEN: per-channel interrupt enable; [31] enables overflow. Reset 0.
  - 0x18 TRIM: see Optional Feature.
  - 0x40+8*i CMP_i: compare value. Reset 0.
  - 0x44+8*i PER_i: period; 0 = one-shot. Reset 0.
- Prescaler:
  - DIV_W down-counter div, reset value PRESC_RST.
  - When EN=0, div holds.
  - When EN=1: if div==0 then tick=1 and div<=reload, else div<=div-1.
  - reload = PRESC, so the tick period is PRESC+1 cycles.
  - A write to PRESC or COUNT, or a 0->1 transition of EN, loads div<=PRESC in the same edge. No tick occurs in that cycle.
  - tick_o is the registered tick: high for the one cycle after the count update.
- Counter:
  - On tick, count<=count+1 modulo 2^CNT_W.
  - Wrap from all-ones to 0 sets STATUS[31].
  - A COUNT write takes priority over a tick in the same cycle: the written value is loaded, with no increment and no match evaluation.
- Match (per channel i), evaluated only on a tick:
  - Condition: CHEN[i] & (count+1 == CMP_i).
  - On match, STATUS[i]<=1 in the same edge as the count update.
  - Periodic (PER_i!=0): CMP_i<=CMP_i+PER_i, modulo 2^CNT_W.
  - One-shot (PER_i==0): CHEN[i]<=0.
  - A software write to CMP_i or CHEN in the same cycle as a hardware update wins over the hardware update.
- STATUS:
  - Hardware set and W1C in the same cycle: the set wins (bit stays 1).
  - Writing 0 has no effect.
- irq_o:
  - irq_o = GIE & |((STATUS[NUM_ALARMS-1:0] & IRQEN[NUM_ALARMS-1:0]) | (STATUS[31] & IRQEN[31])).
  - Registered: one cycle after the STATUS/IRQEN/GIE change.
- Reset:
  - All registers, div, tick_o and irq_o return to their reset values asynchronously.
  - An in-progress access is dropped.

Optional Feature:
- Macro: RTC_TRIM_EN.
- With the macro defined:
  - TRIM register: [7:0] signed adjust ADJ, [23:16] interval N. Reset 0.
  - An internal second counter tcnt counts ticks 0..N. The reload following the tick where tcnt==N is PRESC+ADJ, saturated to the range 0..2^DIV_W-1; tcnt then wraps to 0.
  - All other reloads use PRESC.
  - ADJ=0 disables trimming.
- Without the macro: TRIM reads 0, writes are ignored with pslverr=0, and reload is always PRESC.

Test Plan:
- PRESC=3, COUNT=0, EN=1 -> tick_o pulses every 4 cycles; after 10 ticks COUNT reads 10.
- CMP_0=5, PER_0=0, CHEN=1, IRQEN=1, GIE=1 -> STATUS[0]=1 on the 5th tick and CHEN[0] reads 0. irq_o rises 1 cycle later. W1C of STATUS=1 drops irq_o 1 cycle after the write.
- CMP_1=2, PER_1=3, CHEN=2 -> STATUS[1] sets at counts 2, 5 and 8, clearing it by W1C after each; CMP_1 reads 11 after count 8.
- COUNT=0xFFFFFFFE, EN=1, IRQEN[31]=1, GIE=1 -> second tick gives COUNT=0, STATUS[31]=1, irq_o=1.
- COUNT write timed on the tick cycle with value 100 -> COUNT reads 100 and no match is raised for CMP=101. W1C of STATUS[0] on the same cycle as a channel-0 match -> STATUS[0] stays 1.
- RTC_TRIM_EN defined, PRESC=9, TRIM={N=1,ADJ=+2} -> tick spacing alternates 10, 12, 10, 12 cycles. Without the macro -> TRIM reads 0 and spacing stays 10.

Source files
------------

// File: rtl/apb_rtc_multi_alarm.sv
// APB3 binary seconds counter: prescaled tick, NUM_ALARMS one-shot/periodic compare channels, one level irq.
// Define RTC_TRIM_EN to enable the periodic prescaler trim (TRIM register); otherwise TRIM reads 0.
module apb_rtc_multi_alarm #(
  parameter int CNT_W      = 32,
  parameter int DIV_W      = 16,
  parameter int NUM_ALARMS = 4,
  parameter int PRESC_RST  = 32767
) (
  input  logic        pclk,
  input  logic        prst_n,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [11:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic        tick_o,
  output logic        irq_o
);
  localparam int NA = NUM_ALARMS;

  logic                     r_en, r_gie, r_ovf, r_ovf_ie;
  logic [DIV_W-1:0]         r_presc, r_div, w_reload, w_load_val;
  logic [CNT_W-1:0]         r_count, w_cnt_inc;
  logic [NA-1:0]            r_pend, r_chen, r_ie;
  logic [NA-1:0]            w_match, w_disarm, w_cmp_sel, w_per_sel, w_pend_clr;
  logic [NA-1:0][CNT_W-1:0] r_cmp, r_per;
  logic                     w_wr, w_rd, w_load, w_tick, w_ovf_clr, w_mapped;
  logic                     w_s_ctrl, w_s_presc, w_s_count, w_s_status, w_s_chen, w_s_irqen, w_s_trim;
  logic [5:0]               w_idx;
  logic [31:0]              w_rdata, w_trim_rd;
  logic                     w_unused;

  assign w_wr       = psel & penable & pwrite;
  assign w_rd       = psel & penable & ~pwrite;
  assign w_idx      = paddr[7:2];
  assign w_s_ctrl   = (w_idx == 6'd0);
  assign w_s_presc  = (w_idx == 6'd1);
  assign w_s_count  = (w_idx == 6'd2);
  assign w_s_status = (w_idx == 6'd3);
  assign w_s_chen   = (w_idx == 6'd4);
  assign w_s_irqen  = (w_idx == 6'd5);
  assign w_s_trim   = (w_idx == 6'd6);
  assign w_mapped   = (w_idx <= 6'd6) | (|w_cmp_sel) | (|w_per_sel);
  assign pready     = 1'b1;
  assign pslverr    = psel & penable & ~w_mapped;
  assign w_unused   = &{1'b0, paddr[11:8], paddr[1:0], pwdata};

  // Any div reload from software suppresses the tick of that edge; a PRESC write reloads the new value.
  assign w_load     = w_wr & ((w_s_ctrl & pwdata[0] & ~r_en) | w_s_presc | w_s_count);
  assign w_load_val = (w_wr & w_s_presc) ? pwdata[DIV_W-1:0] : r_presc;
  assign w_tick     = r_en & (r_div == '0) & ~w_load;
  assign w_cnt_inc  = r_count + CNT_W'(1);
  assign w_pend_clr = {NA{w_wr & w_s_status}} & pwdata[NA-1:0];
  assign w_ovf_clr  = w_wr & w_s_status & pwdata[31];

  for (genvar i = 0; i < NA; i++) begin : g_ch
    assign w_cmp_sel[i] = (w_idx == 6'(16 + 2*i));
    assign w_per_sel[i] = (w_idx == 6'(17 + 2*i));
    assign w_match[i]   = w_tick & r_chen[i] & (w_cnt_inc == r_cmp[i]);
    assign w_disarm[i]  = w_match[i] & (r_per[i] == '0);
  end

`ifdef RTC_TRIM_EN
  localparam logic [31:0] DIV_MAX = 32'((64'd1 << DIV_W) - 64'd1);
  logic [7:0]         r_adj, r_tn, r_tcnt;
  logic signed [31:0] w_sum;

  assign w_sum     = $signed({{(32-DIV_W){1'b0}}, r_presc}) + $signed({{24{r_adj[7]}}, r_adj});
  assign w_trim_rd = {8'h00, r_tn, 8'h00, r_adj};

  always_comb begin
    w_reload = r_presc;
    if (r_tcnt == r_tn) begin
      if (w_sum < 0)                        w_reload = '0;
      else if ($unsigned(w_sum) > DIV_MAX) w_reload = DIV_MAX[DIV_W-1:0];
      else                                  w_reload = w_sum[DIV_W-1:0];
    end
  end

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      r_adj  <= '0;
      r_tn   <= '0;
      r_tcnt <= '0;
    end else if (w_wr & w_s_trim) begin
      r_adj  <= pwdata[7:0];
      r_tn   <= pwdata[23:16];
      r_tcnt <= '0;
    end else if (w_tick) begin
      r_tcnt <= (r_tcnt == r_tn) ? 8'd0 : r_tcnt + 8'd1;
    end
  end
`else
  assign w_reload  = r_presc;
  assign w_trim_rd = '0;
`endif

  always_comb begin
    w_rdata = '0;
    case (w_idx)
      6'd0: w_rdata[1:0] = {r_gie, r_en};
      6'd1: w_rdata[DIV_W-1:0] = r_presc;
      6'd2: w_rdata[CNT_W-1:0] = r_count;
      6'd3: begin w_rdata[NA-1:0] = r_pend; w_rdata[31] = r_ovf; end
      6'd4: w_rdata[NA-1:0] = r_chen;
      6'd5: begin w_rdata[NA-1:0] = r_ie; w_rdata[31] = r_ovf_ie; end
      6'd6: w_rdata = w_trim_rd;
      default: ;
    endcase
    for (int i = 0; i < NA; i++) begin
      if (w_cmp_sel[i]) w_rdata[CNT_W-1:0] = r_cmp[i];
      if (w_per_sel[i]) w_rdata[CNT_W-1:0] = r_per[i];
    end
  end
  assign prdata = w_rd ? w_rdata : '0;

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      r_en     <= 1'b0;
      r_gie    <= 1'b0;
      r_presc  <= DIV_W'(PRESC_RST);
      r_div    <= DIV_W'(PRESC_RST);
      r_count  <= '0;
      r_pend   <= '0;
      r_ovf    <= 1'b0;
      r_chen   <= '0;
      r_ie     <= '0;
      r_ovf_ie <= 1'b0;
      r_cmp    <= '0;
      r_per    <= '0;
      tick_o   <= 1'b0;
      irq_o    <= 1'b0;
    end else begin
      if (w_wr & w_s_ctrl) begin
        r_en  <= pwdata[0];
        r_gie <= pwdata[1];
      end
      if (w_wr & w_s_presc) r_presc <= pwdata[DIV_W-1:0];
      if (w_load)     r_div <= w_load_val;
      else if (r_en)  r_div <= (r_div == '0) ? w_reload : r_div - DIV_W'(1);
      tick_o <= w_tick;
      if (w_wr & w_s_count) r_count <= pwdata[CNT_W-1:0];
      else if (w_tick)      r_count <= w_cnt_inc;
      // Hardware set beats a same-cycle W1C.
      r_pend <= w_match | (r_pend & ~w_pend_clr);
      r_ovf  <= (w_tick & (&r_count)) | (r_ovf & ~w_ovf_clr);
      if (w_wr & w_s_chen) r_chen <= pwdata[NA-1:0];
      else                 r_chen <= r_chen & ~w_disarm;
      if (w_wr & w_s_irqen) begin
        r_ie     <= pwdata[NA-1:0];
        r_ovf_ie <= pwdata[31];
      end
      for (int i = 0; i < NA; i++) begin
        if (w_wr & w_cmp_sel[i]) r_cmp[i] <= pwdata[CNT_W-1:0];
        else if (w_match[i])     r_cmp[i] <= r_cmp[i] + r_per[i];
        if (w_wr & w_per_sel[i]) r_per[i] <= pwdata[CNT_W-1:0];
      end
      irq_o <= r_gie & ((|(r_pend & r_ie)) | (r_ovf & r_ovf_ie));
    end
  end
endmodule

// File: tb/tb_apb_rtc_multi_alarm.sv
// Bench for apb_rtc_multi_alarm: reset/decode vector table, directed timing sequences, randomized alarm trials.
module tb_apb_rtc_multi_alarm;
  localparam logic [11:0] A_CTRL = 12'h000, A_PRESC = 12'h004, A_COUNT = 12'h008, A_STATUS = 12'h00C;
  localparam logic [11:0] A_CHEN = 12'h010, A_IRQEN = 12'h014, A_TRIM = 12'h018;
  localparam logic [11:0] A_CMP0 = 12'h040, A_PER0 = 12'h044, A_CMP1 = 12'h048, A_PER1 = 12'h04C;

  logic        pclk = 1'b0, prst_n = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [11:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready, pslverr, tick_o, irq_o;
  int          errors = 0, checks = 0, cyc = 0;

  apb_rtc_multi_alarm dut (
    .pclk(pclk), .prst_n(prst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .tick_o(tick_o), .irq_o(irq_o)
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] exp;
    logic        err;
    string       name;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(input logic [11:0] a, input logic [31:0] e, input logic er, input string n);
    vec_t v;
    v.addr = a; v.exp = e; v.err = er; v.name = n;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Each access returns at the negedge after its access edge; cyc then equals that edge's index.
  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    @(negedge pclk); psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = d;
    @(negedge pclk); penable = 1'b1;
    @(negedge pclk); psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] d, output logic e);
    @(negedge pclk); psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = a;
    @(negedge pclk); penable = 1'b1;
    #1 d = prdata; e = pslverr;
    @(negedge pclk); psel = 1'b0; penable = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic        e;
    rd(a, d, e);
    chk(name, d, exp);
  endtask

  // Lands the write exactly on posedge index e.
  task automatic wr_at(input int e, input logic [11:0] a, input logic [31:0] d);
    if (cyc > e - 3) begin
      checks++; errors++;
      $display("FAIL wr_at_late: at cycle %0d, target edge %0d", cyc, e);
    end
    while (cyc < e - 3) @(negedge pclk);
    wr(a, d);
  endtask

  task automatic wait_tick(output int t);
    int n;
    n = 0;
    do begin
      @(negedge pclk); n++;
    end while (!tick_o && n < 500);
    if (!tick_o) begin
      checks++; errors++;
      $display("FAIL tick_timeout: no tick_o within %0d cycles, expected a pulse", n);
    end
    t = cyc;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, c0, cmp, exp_cmp, exp_st;
    logic        e, ovf;
    int          t, tp, e0, ed;
    int unsigned p, w, k, per, tt, m;

    repeat (3) @(negedge pclk);
    chk("rst_irq", {31'b0, irq_o}, 32'd0);
    chk("rst_tick", {31'b0, tick_o}, 32'd0);
    prst_n = 1'b1;

    // Reset values and address decode, including an alias above bit 7 and unmapped holes.
    tbl.push_back(mk(A_CTRL,   32'd0,     1'b0, "ctrl"));
    tbl.push_back(mk(A_PRESC,  32'd32767, 1'b0, "presc"));
    tbl.push_back(mk(A_COUNT,  32'd0,     1'b0, "count"));
    tbl.push_back(mk(A_STATUS, 32'd0,     1'b0, "status"));
    tbl.push_back(mk(A_CHEN,   32'd0,     1'b0, "chen"));
    tbl.push_back(mk(A_IRQEN,  32'd0,     1'b0, "irqen"));
    tbl.push_back(mk(A_TRIM,   32'd0,     1'b0, "trim"));
    tbl.push_back(mk(A_CMP0,   32'd0,     1'b0, "cmp0"));
    tbl.push_back(mk(12'h05C,  32'd0,     1'b0, "per3"));
    tbl.push_back(mk(12'h104,  32'd32767, 1'b0, "presc_alias"));
    tbl.push_back(mk(12'h01C,  32'd0,     1'b1, "hole_1c"));
    tbl.push_back(mk(12'h03C,  32'd0,     1'b1, "hole_3c"));
    tbl.push_back(mk(12'h060,  32'd0,     1'b1, "past_ch3"));
    for (int i = 0; i < tbl.size(); i++) begin
      rd(tbl[i].addr, d, e);
      chk({"rst_rd_", tbl[i].name}, d, tbl[i].exp);
      chk({"rst_err_", tbl[i].name}, {31'b0, e}, {31'b0, tbl[i].err});
    end

    // Basic counting: PRESC=3 gives a 4-cycle tick period.
    wr(A_CTRL, 0); wr(A_PRESC, 3); wr(A_COUNT, 0); wr(A_CTRL, 1);
    e0 = cyc;
    wait_tick(t);
    chk("first_tick_lat", 32'(t - e0), 32'd4);
    for (int i = 2; i <= 10; i++) begin
      tp = t;
      wait_tick(t);
      if (i <= 4) chk("tick_spacing", 32'(t - tp), 32'd4);
    end
    wr(A_CTRL, 0);
    rd_chk("count_10", A_COUNT, 32'd10);

    // One-shot alarm and registered irq timing.
    wr(A_STATUS, 32'hFFFF_FFFF); wr(A_COUNT, 0); wr(A_CMP0, 5); wr(A_PER0, 0);
    wr(A_CHEN, 1); wr(A_IRQEN, 1); wr(A_CTRL, 3);
    for (int i = 0; i < 5; i++) wait_tick(t);
    chk("irq_lag", {31'b0, irq_o}, 32'd0);
    @(negedge pclk);
    chk("irq_rise", {31'b0, irq_o}, 32'd1);
    rd_chk("oneshot_status", A_STATUS, 32'd1);
    rd_chk("oneshot_chen", A_CHEN, 32'd0);
    wr(A_STATUS, 1);
    chk("irq_hold", {31'b0, irq_o}, 32'd1);
    @(negedge pclk);
    chk("irq_clear", {31'b0, irq_o}, 32'd0);
    wr(A_CTRL, 0);

    // Periodic channel 1: matches at 2, 5, 8; cleared by W1C after each.
    wr(A_PRESC, 9); wr(A_COUNT, 0); wr(A_CMP1, 2); wr(A_PER1, 3); wr(A_CHEN, 2);
    wr(A_IRQEN, 0); wr(A_STATUS, 32'hFFFF_FFFF); wr(A_CTRL, 1);
    for (int j = 1; j <= 8; j++) begin
      wait_tick(t);
      rd(A_STATUS, d, e);
      chk($sformatf("per_status_%0d", j), d, (j % 3 == 2) ? 32'd2 : 32'd0);
      if (d[1]) wr(A_STATUS, 2);
    end
    rd_chk("per_cmp1", A_CMP1, 32'd11);
    wr(A_CTRL, 0);

    // Counter wrap sets overflow and raises irq.
    wr(A_CHEN, 0); wr(A_STATUS, 32'hFFFF_FFFF); wr(A_PRESC, 3); wr(A_COUNT, 32'hFFFF_FFFE);
    wr(A_IRQEN, 32'h8000_0000); wr(A_CTRL, 3);
    wait_tick(t); wait_tick(t);
    rd_chk("wrap_count", A_COUNT, 32'd0);
    rd_chk("wrap_status", A_STATUS, 32'h8000_0000);
    chk("wrap_irq", {31'b0, irq_o}, 32'd1);
    wr(A_CTRL, 0);

    // COUNT write on a tick edge; W1C racing a match.
    wr(A_STATUS, 32'hFFFF_FFFF); wr(A_IRQEN, 0); wr(A_PRESC, 20); wr(A_COUNT, 99);
    wr(A_CMP0, 101); wr(A_PER0, 0); wr(A_CHEN, 1); wr(A_CTRL, 1);
    wait_tick(t);
    wr_at(t + 21, A_COUNT, 100);
    chk("cntwr_no_tick", {31'b0, tick_o}, 32'd0);
    rd_chk("cntwr_status", A_STATUS, 32'd0);
    rd_chk("cntwr_count", A_COUNT, 32'd100);
    wr_at(t + 42, A_STATUS, 1);
    chk("race_tick", {31'b0, tick_o}, 32'd1);
    rd_chk("race_status", A_STATUS, 32'd1);
    rd_chk("race_chen", A_CHEN, 32'd0);
    wr(A_CTRL, 0);

    // Trim: N=1, ADJ=+2 stretches every second tick interval by 2 cycles.
    wr(A_PRESC, 9); wr(A_TRIM, 32'h0001_0002);
`ifdef RTC_TRIM_EN
    rd_chk("trim_rd", A_TRIM, 32'h0001_0002);
`else
    rd_chk("trim_rd", A_TRIM, 32'd0);
`endif
    wr(A_CTRL, 1);
    wait_tick(t);
    for (int i = 0; i < 3; i++) begin
      tp = t;
      wait_tick(t);
`ifdef RTC_TRIM_EN
      chk($sformatf("trim_spacing_%0d", i), 32'(t - tp), (i == 1) ? 32'd12 : 32'd10);
`else
      chk($sformatf("trim_spacing_%0d", i), 32'(t - tp), 32'd10);
`endif
    end
    wr(A_CTRL, 0); wr(A_TRIM, 0);

    // Random trials: expected state from elapsed time and the match arithmetic.
    for (int r = 0; r < 8; r++) begin
      p   = $urandom_range(0, 4);
      w   = $urandom_range(5, 60);
      k   = $urandom_range(1, 15);
      per = $urandom_range(0, 3);
      c0  = (r % 2 == 0) ? $urandom() : 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
      cmp = c0 + k;
      wr(A_CTRL, 0); wr(A_PRESC, p); wr(A_COUNT, c0); wr(A_CMP0, cmp); wr(A_PER0, per);
      wr(A_CHEN, 1); wr(A_IRQEN, 32'h8000_0001); wr(A_STATUS, 32'hFFFF_FFFF);
      wr(A_CTRL, 3);
      e0 = cyc;
      repeat (w) @(negedge pclk);
      wr(A_CTRL, 2);
      ed = cyc;
      tt = 32'(ed - e0) / (p + 1);
      if (tt < k)        m = 0;
      else if (per == 0) m = 1;
      else               m = 1 + (tt - k) / per;
      exp_cmp = cmp + m * per;
      ovf     = ({32'd0, c0} + 64'(tt)) > 64'h0000_0000_FFFF_FFFF;
      exp_st  = {ovf, 30'd0, (m > 0)};
      rd_chk($sformatf("rnd%0d_count", r), A_COUNT, c0 + tt);
      rd_chk($sformatf("rnd%0d_status", r), A_STATUS, exp_st);
      rd_chk($sformatf("rnd%0d_chen", r), A_CHEN, (per == 0 && m > 0) ? 32'd0 : 32'd1);
      rd_chk($sformatf("rnd%0d_cmp", r), A_CMP0, exp_cmp);
      chk($sformatf("rnd%0d_irq", r), {31'b0, irq_o}, {31'b0, (m > 0) | ovf});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
